// File: rtl/ahb_led_pwm.sv
// AHB-Lite LED PWM controller: per-channel duty, prescaled PWM counter, blink gating, period-done IRQ.
// Latency: zero-wait-state register access; duty changes reach LED_OUT at the next PWM period start.
// Backpressure: HREADYOUT drops only in the first cycle of an ERROR response; otherwise always ready.
module ahb_led_pwm #(
  parameter int NUM_CH     = 8,
  parameter int PWM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [ADDR_WIDTH+1:2]   HADDR,
  input  logic                    HSEL,
  input  logic                    HWRITE,
  input  logic [31:0]             HWDATA,
  input  logic [1:0]              HTRANS,
  input  logic [2:0]              HSIZE,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [31:0]             HRDATA,
  output logic [NUM_CH-1:0]       LED_OUT,
  output logic                    IRQ
);

  localparam logic [PWM_WIDTH-1:0] PWM_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} err_state_t;

  err_state_t r_state, w_state_nxt;

  logic                  r_dp_vld, r_dp_write;
  logic [ADDR_WIDTH-1:0] r_dp_addr;
  logic                  r_en, r_blink_en, r_irq_en, r_pdone, r_phase;
  logic [15:0]           r_presc, r_presc_act, r_presc_cnt, r_blink, r_blink_cnt;
  logic [PWM_WIDTH-1:0]  r_pwm_cnt;
  logic [PWM_WIDTH-1:0]  r_duty     [NUM_CH];
  logic [PWM_WIDTH-1:0]  r_act_duty [NUM_CH];

  logic w_accept, w_addr_legal, w_wr, w_tick, w_pend, w_blink_on, w_phase;
  logic w_unused;

  assign w_accept     = HSEL && HREADY && HTRANS[1];
  assign w_addr_legal = (HADDR < ADDR_WIDTH'(4)) ||
                        ((HADDR >= ADDR_WIDTH'(16)) && (HADDR < ADDR_WIDTH'(16 + NUM_CH)));
  assign w_wr         = r_dp_vld && r_dp_write && HREADY;
  assign w_tick       = r_en && (r_presc_cnt == r_presc_act);
  assign w_pend       = w_tick && (r_pwm_cnt == PWM_MAX);
  assign w_blink_on   = r_blink_en && (r_blink != 16'd0);
  assign w_phase      = !w_blink_on || r_phase;
  assign IRQ          = r_pdone && r_irq_en;
  assign w_unused     = ^{HSIZE, HTRANS[0], HWDATA[31:16]};

  // Capture the address phase of legal transfers for the following data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_dp_vld   <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else if (HREADY) begin
      r_dp_vld   <= w_accept && w_addr_legal;
      r_dp_write <= HWRITE;
      r_dp_addr  <= HADDR;
    end
  end

  // Error-response state register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Error-response sequencing: stall one cycle with ERROR, then complete with ERROR.
  always_comb begin
    w_state_nxt = S_IDLE;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    case (r_state)
      S_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        w_state_nxt = S_ERR2;
      end
      S_ERR2: begin
        HRESP       = 1'b1;
        w_state_nxt = (w_accept && !w_addr_legal) ? S_ERR1 : S_IDLE;
      end
      default: w_state_nxt = (w_accept && !w_addr_legal) ? S_ERR1 : S_IDLE;
    endcase
  end

  // Software-visible configuration registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_en       <= 1'b0;
      r_blink_en <= 1'b0;
      r_irq_en   <= 1'b0;
      r_presc    <= 16'd0;
      r_blink    <= 16'd0;
      for (int i = 0; i < NUM_CH; i++) r_duty[i] <= '0;
    end else if (w_wr) begin
      if (r_dp_addr == ADDR_WIDTH'(0)) {r_irq_en, r_blink_en, r_en} <= HWDATA[2:0];
      if (r_dp_addr == ADDR_WIDTH'(1)) r_presc <= HWDATA[15:0];
      if (r_dp_addr == ADDR_WIDTH'(3)) r_blink <= HWDATA[15:0];
      for (int i = 0; i < NUM_CH; i++)
        if (r_dp_addr == ADDR_WIDTH'(16 + i)) r_duty[i] <= HWDATA[PWM_WIDTH-1:0];
    end
  end

  // Period-done flag: a period end beats a simultaneous write-1-to-clear.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)                                           r_pdone <= 1'b0;
    else if (w_pend)                                        r_pdone <= 1'b1;
    else if (w_wr && r_dp_addr == ADDR_WIDTH'(2) && HWDATA[0]) r_pdone <= 1'b0;
  end

  // Prescaler and PWM counter; a new PRESC is adopted only at a prescaler wrap or while disabled.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_presc_cnt <= 16'd0;
      r_presc_act <= 16'd0;
      r_pwm_cnt   <= '0;
    end else if (!r_en) begin
      r_presc_cnt <= 16'd0;
      r_presc_act <= r_presc;
      r_pwm_cnt   <= '0;
    end else if (w_tick) begin
      r_presc_cnt <= 16'd0;
      r_presc_act <= r_presc;
      r_pwm_cnt   <= r_pwm_cnt + 1'b1;
    end else begin
      r_presc_cnt <= r_presc_cnt + 16'd1;
    end
  end

  // Active duties follow DUTY only at period end (or freely while disabled) to avoid runt pulses.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_CH; i++) r_act_duty[i] <= '0;
    end else if (!r_en || w_pend) begin
      for (int i = 0; i < NUM_CH; i++) r_act_duty[i] <= r_duty[i];
    end
  end

  // Blink: count period ends and toggle phase every BLINK periods.
  always_ff @(posedge HCLK) begin
    if (!HRESETn || !r_en || !w_blink_on) begin
      r_blink_cnt <= 16'd0;
      r_phase     <= 1'b1;
    end else if (w_pend) begin
      if (r_blink_cnt >= r_blink - 16'd1) begin
        r_blink_cnt <= 16'd0;
        r_phase     <= !r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 16'd1;
      end
    end
  end

  // LED drive: all-ones duty means permanently on within the active phase.
  always_comb begin
    LED_OUT = '0;
    for (int i = 0; i < NUM_CH; i++)
      LED_OUT[i] = r_en && w_phase &&
                   ((r_act_duty[i] == PWM_MAX) || (r_pwm_cnt < r_act_duty[i]));
  end

  // Read mux for the data phase of a legal read; zero otherwise.
  always_comb begin
    HRDATA = 32'd0;
    if (r_dp_vld && !r_dp_write) begin
      if (r_dp_addr == ADDR_WIDTH'(0)) HRDATA[2:0]  = {r_irq_en, r_blink_en, r_en};
      if (r_dp_addr == ADDR_WIDTH'(1)) HRDATA[15:0] = r_presc;
      if (r_dp_addr == ADDR_WIDTH'(2)) HRDATA[0]    = r_pdone;
      if (r_dp_addr == ADDR_WIDTH'(3)) HRDATA[15:0] = r_blink;
      for (int i = 0; i < NUM_CH; i++)
        if (r_dp_addr == ADDR_WIDTH'(16 + i)) HRDATA[PWM_WIDTH-1:0] = r_duty[i];
    end
  end

endmodule

// File: doc/ahb_led_pwm.md
AHB_LED_PWM -- requirements
Module: ahb_led_pwm

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning number of LED channels (legal range 1..16).
REQ-002 SHALL have parameter PWM_WIDTH, default 8, meaning duty/PWM counter width (legal range 2..16).
REQ-003 SHALL have parameter ADDR_WIDTH, default 18, meaning word-address width of HADDR.
REQ-004 SHALL have one clock and a synchronous, active-low reset; the ports are listed below.
REQ-005 SHALL have port HCLK, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-006 SHALL have port HRESETn, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have AHB slave inputs:
- HADDR, ADDR_WIDTH+1:2, word address.
- HSEL, 1 bit.
- HWRITE, 1 bit.
- HWDATA, 32 bits.
- HTRANS, 2 bits.
- HSIZE, 3 bits, unused.
- HREADY, 1 bit.
REQ-008 SHALL have AHB slave outputs:
- HREADYOUT, 1 bit.
- HRESP, 1 bit.
- HRDATA, 32 bits.
REQ-009 SHALL have LED_OUT, output, NUM_CH bits: PWM drive per channel.
REQ-010 SHALL have IRQ, output, 1 bit: period-done interrupt.

Function
REQ-011 SHALL accept a transfer only when HSEL && HREADY && HTRANS is NONSEQ or SEQ; the address, direction and select SHALL then be registered for the data phase.
REQ-012 SHALL implement this word-address map (all other addresses are illegal):
- 0 CTRL: bit0 EN, bit1 BLINK_EN, bit2 IRQ_EN.
- 1 PRESC: bits 15:0.
- 2 STATUS: bit0 PDONE, write-1-to-clear.
- 3 BLINK: bits 15:0, half-period counted in PWM periods.
- 16+i, for i < NUM_CH: DUTY[i], bits PWM_WIDTH-1:0.
REQ-013 SHALL commit a write using HWDATA in the data-phase cycle where HREADY=1; unused register bits SHALL be ignored on write and read as 0.
REQ-014 SHALL drive HRDATA combinationally during a read data phase from the registered address; HRDATA SHALL be 0 otherwise.
- A read that immediately follows a write to the same register SHALL return the new value.
REQ-015 SHALL give an illegal address a two-cycle ERROR response:
- cycle 1: HREADYOUT=0, HRESP=1.
- cycle 2: HREADYOUT=1, HRESP=1.
- No register SHALL change.
REQ-016 SHALL drive HREADYOUT=1 and HRESP=0 (OKAY) for all legal transfers, with zero wait states.
REQ-017 SHALL run a prescaler, while EN=1, that counts 0..PRESC and asserts a 1-cycle tick on reaching PRESC; PRESC=0 SHALL give a tick every cycle.
- A new PRESC value SHALL take effect at the next prescaler wrap.
REQ-018 SHALL advance a PWM counter by 1 on each tick, wrapping from 2^PWM_WIDTH-1 to 0; that wrap is a "period end".
REQ-019 SHALL hold an active duty per channel that loads from DUTY[i] only at period end, giving glitch-free updates.
REQ-020 SHALL compute LED_OUT[i] = EN && phase && (pwm_cnt < active_duty[i]), except that active_duty = all-ones SHALL force the output on whenever EN && phase.
REQ-021 SHALL implement blink as follows:
- phase=1 when BLINK_EN=0 or BLINK=0.
- Otherwise a period counter counts period ends and toggles phase after each BLINK period ends, then restarts from 0.
- phase SHALL start at 1.
REQ-022 SHALL set PDONE at every period end, and set SHALL win over a simultaneous write-1-clear.
REQ-023 SHALL drive IRQ = PDONE && IRQ_EN.
REQ-024 SHALL, when EN is written 0:
- within 1 cycle, clear the prescaler, PWM counter and blink counter and set phase to 1;
- force LED_OUT to 0;
- load the active duties directly from DUTY.
REQ-025 SHALL, when EN goes 0 to 1, produce the first tick PRESC+1 cycles later.

Reset
REQ-026 SHALL, on HRESETn=0 at a clock edge, clear all registers, counters, active duties and PDONE, and drive HREADYOUT=1, HRESP=0, HRDATA=0, LED_OUT=0, IRQ=0.
REQ-027 SHALL, on reset asserted mid-transfer, abandon the pending write or error and commit no register update.

Verification
REQ-028 SHALL be covered by this case: PRESC=0, DUTY[0]=64, EN=1 (PWM_WIDTH=8) -> LED_OUT[0] high 64 of every 256 cycles, period 256 cycles.
REQ-029 SHALL be covered by this case: DUTY[0] written 64 to 192 mid-period -> pulse width changes only from the next period start; no runt pulse.
REQ-030 SHALL be covered by this case: read of word address 16+NUM_CH -> HREADYOUT 0 then 1, HRESP 1 for both cycles, registers unchanged.
REQ-031 SHALL be covered by this case: BLINK_EN=1, BLINK=2 -> LED_OUT[i] active for 2 periods, then forced 0 for 2 periods, repeating.
REQ-032 SHALL be covered by this case: IRQ_EN=1, write STATUS=1 in the same cycle as a period end -> PDONE stays 1 and IRQ stays 1.
REQ-033 SHALL be covered by this case: DUTY[i]=all-ones -> LED_OUT[i] constant 1; then EN=0 -> LED_OUT=0 next cycle, counters 0.
